// File: rtl/bp_pkg.sv
// Shared types and width helpers for the branch predictor (table entry, 2-bit counter).
package bp_pkg;

    // Upper bound on XLEN; entry fields are sized to this and zero-extended.
    localparam int BP_MAX_XLEN = 64;

    typedef enum logic [1:0] {
        BP_SNT = 2'd0,
        BP_WNT = 2'd1,
        BP_WT  = 2'd2,
        BP_ST  = 2'd3
    } bp_ctr_e;

    typedef struct packed {
        logic                   valid;
        logic [BP_MAX_XLEN-1:0] tag;
        logic [BP_MAX_XLEN-1:0] target;
        logic                   jump;
        bp_ctr_e                ctr;
    } bp_entry_t;

    function automatic int bp_idx_w(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int bp_tag_w(input int xlen, input int entries);
        return xlen - bp_idx_w(entries) - 2;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating 2-bit branch counter: steps toward ST on taken, toward SNT otherwise.
module bp_sat_counter
    import bp_pkg::*;
(
    input  bp_ctr_e state_i,
    input  logic    taken_i,
    output bp_ctr_e next_o
);

    always_comb begin
        next_o = state_i;
        if (taken_i) begin
            if (state_i != BP_ST) begin
                next_o = bp_ctr_e'(state_i + 2'd1);
            end
        end else begin
            if (state_i != BP_SNT) begin
                next_o = bp_ctr_e'(state_i - 2'd1);
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit counter branch predictor with execute-stage resolution.
// Optional statistics counters are enabled by defining BP_STATS_EN.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_f,
    output logic            pred_taken_f,
    output logic [XLEN-1:0] pred_target_f,
    input  logic            update_valid_e,
    input  logic [XLEN-1:0] pc_e,
    input  logic            is_branch_e,
    input  logic            is_jump_e,
    input  logic            taken_e,
    input  logic [XLEN-1:0] target_e,
    input  logic            pred_taken_e,
    input  logic [XLEN-1:0] pred_target_e,
    output logic            mispredict_e,
    output logic [XLEN-1:0] redirect_pc_e
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int IDX_W = bp_idx_w(ENTRIES);
    localparam int TAG_W = bp_tag_w(XLEN, ENTRIES);

    logic [IDX_W-1:0]       idx_f;
    logic [IDX_W-1:0]       idx_e;
    logic [BP_MAX_XLEN-1:0] tag_f;
    logic [BP_MAX_XLEN-1:0] tag_e;
    logic [BP_MAX_XLEN-1:0] target_ext_e;
    bp_entry_t              table_rd [ENTRIES];
    bp_entry_t              rd_f;
    bp_entry_t              rd_e;
    bp_entry_t              entry_d;
    logic                   hit_f;
    logic                   hit_e;
    logic                   ctrl_e;
    logic                   wr_en_e;
    bp_ctr_e                ctr_next_e;

    assign idx_f        = pc_f[IDX_W+1:2];
    assign idx_e        = pc_e[IDX_W+1:2];
    assign tag_f        = BP_MAX_XLEN'(pc_f[IDX_W+2 +: TAG_W]);
    assign tag_e        = BP_MAX_XLEN'(pc_e[IDX_W+2 +: TAG_W]);
    assign target_ext_e = BP_MAX_XLEN'(target_e);

    // Lookup reads the registered table, so a same-cycle update is seen next cycle.
    assign rd_f          = table_rd[idx_f];
    assign hit_f         = rd_f.valid && (rd_f.tag == tag_f);
    assign pred_taken_f  = hit_f && (rd_f.jump || (rd_f.ctr >= BP_WT));
    assign pred_target_f = pred_taken_f ? rd_f.target[XLEN-1:0] : pc_f + XLEN'(4);

    assign rd_e   = table_rd[idx_e];
    assign hit_e  = rd_e.valid && (rd_e.tag == tag_e);
    assign ctrl_e = is_branch_e | is_jump_e;

    bp_sat_counter u_sat_counter (
        .state_i (rd_e.ctr),
        .taken_i (taken_e),
        .next_o  (ctr_next_e)
    );

    always_comb begin
        entry_d = rd_e;
        wr_en_e = 1'b0;
        if (update_valid_e) begin
            if (ctrl_e) begin
                if (hit_e) begin
                    wr_en_e       = 1'b1;
                    entry_d.ctr   = ctr_next_e;
                    entry_d.jump  = is_jump_e;
                    if (taken_e) begin
                        entry_d.target = target_ext_e;
                    end
                end else if (taken_e) begin
                    wr_en_e        = 1'b1;
                    entry_d.valid  = 1'b1;
                    entry_d.tag    = tag_e;
                    entry_d.target = target_ext_e;
                    entry_d.jump   = is_jump_e;
                    entry_d.ctr    = BP_WT;
                end
            end else if (hit_e) begin
                // A non-control instruction aliasing an entry means the entry is stale.
                wr_en_e       = 1'b1;
                entry_d.valid = 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            bp_entry_t entry_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    entry_q.valid  <= 1'b0;
                    entry_q.tag    <= '0;
                    entry_q.target <= '0;
                    entry_q.jump   <= 1'b0;
                    entry_q.ctr    <= BP_WNT;
                end else if (wr_en_e && (idx_e == IDX_W'(gi))) begin
                    entry_q <= entry_d;
                end
            end

            assign table_rd[gi] = entry_q;

            if (XLEN < BP_MAX_XLEN) begin : g_pad
                logic unused_target_hi;
                assign unused_target_hi = ^entry_q.target[BP_MAX_XLEN-1:XLEN];
            end
        end
    endgenerate

    assign mispredict_e  = update_valid_e &
                           ((taken_e != pred_taken_e) | (taken_e & (target_e != pred_target_e)));
    assign redirect_pc_e = taken_e ? target_e : pc_e + XLEN'(4);

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispredicts_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (update_valid_e && ctrl_e) begin
                stat_branches_q <= stat_branches_q + 32'd1;
            end
            if (mispredict_e) begin
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`else
    // Statistics hardware is not built; prediction logic is unchanged.
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (XLEN=32, ENTRIES=16).
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        update_valid_e;
    logic [31:0] pc_e;
    logic        is_branch_e;
    logic        is_jump_e;
    logic        taken_e;
    logic [31:0] target_e;
    logic        pred_taken_e;
    logic [31:0] pred_target_e;
    logic        mispredict_e;
    logic [31:0] redirect_pc_e;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int compared   = 0;
    int mismatched = 0;

    branch_predictor #(.XLEN(32), .ENTRIES(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_f           (pc_f),
        .pred_taken_f   (pred_taken_f),
        .pred_target_f  (pred_target_f),
        .update_valid_e (update_valid_e),
        .pc_e           (pc_e),
        .is_branch_e    (is_branch_e),
        .is_jump_e      (is_jump_e),
        .taken_e        (taken_e),
        .target_e       (target_e),
        .pred_taken_e   (pred_taken_e),
        .pred_target_e  (pred_target_e),
        .mispredict_e   (mispredict_e),
        .redirect_pc_e  (redirect_pc_e)
`ifdef BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic br, input logic jmp,
                           input logic tkn, input logic [31:0] tgt);
        update_valid_e = 1'b1;
        pc_e           = pc;
        is_branch_e    = br;
        is_jump_e      = jmp;
        taken_e        = tkn;
        target_e       = tgt;
        pred_taken_e   = 1'b0;
        pred_target_e  = 32'h0;
    endtask

    task automatic clr_upd();
        update_valid_e = 1'b0;
        is_branch_e    = 1'b0;
        is_jump_e      = 1'b0;
        taken_e        = 1'b0;
        pc_e           = 32'h0;
        target_e       = 32'h0;
        pred_taken_e   = 1'b0;
        pred_target_e  = 32'h0;
    endtask

    // Apply one resolved update for exactly one clock edge.
    task automatic upd(input logic [31:0] pc, input logic br, input logic jmp,
                       input logic tkn, input logic [31:0] tgt);
        set_upd(pc, br, jmp, tkn, tgt);
        tick();
        clr_upd();
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic exp_taken, input logic [31:0] exp_target);
        pc_f = pc;
        #1;
        chk({tag, "_tk"}, {31'b0, pred_taken_f}, {31'b0, exp_taken});
        chk({tag, "_tg"}, pred_target_f, exp_target);
    endtask

    initial begin
        reset = 1'b1;
        pc_f  = 32'h0;
        clr_upd();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Empty table after reset
        look("rst", 32'h100, 1'b0, 32'h104);
        chk("rst_misp", {31'b0, mispredict_e}, 32'd0);

        // Allocation; same-cycle lookup still sees the old (empty) entry
        set_upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h80);
        #1;
        chk("alloc_misp", {31'b0, mispredict_e}, 32'd1);
        chk("alloc_redir", redirect_pc_e, 32'h80);
        chk("same_cyc_tk", {31'b0, pred_taken_f}, 32'd0);
        tick();
        clr_upd();
        look("alloc", 32'h100, 1'b1, 32'h80);

        // WT -> WNT -> SNT -> SNT, then back up without underflow
        upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
        look("nt1", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
        upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
        look("nt3", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h88);
        look("t_wnt", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h88);
        look("t_wt", 32'h100, 1'b1, 32'h88);

        // Saturation at ST: two more taken, one not-taken leaves WT
        upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h88);
        upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h88);
        upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
        look("st_sat", 32'h100, 1'b1, 32'h88);

        // Mispredict / redirect combinational checks (non-control pc, no table effect)
        update_valid_e = 1'b1;
        pc_e           = 32'h200;
        pred_taken_e   = 1'b1;
        pred_target_e  = 32'h80;
        taken_e        = 1'b1;
        target_e       = 32'h90;
        #1;
        chk("tgt_misp", {31'b0, mispredict_e}, 32'd1);
        chk("tgt_redir", redirect_pc_e, 32'h90);
        pred_target_e = 32'h90;
        #1;
        chk("ok_misp", {31'b0, mispredict_e}, 32'd0);
        pc_e    = 32'h100;
        taken_e = 1'b0;
        #1;
        chk("nt_misp", {31'b0, mispredict_e}, 32'd1);
        chk("nt_redir", redirect_pc_e, 32'h104);
        pred_taken_e = 1'b0;
        #1;
        chk("nt_ok_misp", {31'b0, mispredict_e}, 32'd0);
        pred_taken_e   = 1'b1;
        update_valid_e = 1'b0;
        #1;
        chk("inval_misp", {31'b0, mispredict_e}, 32'd0);
        clr_upd();

        // Update inputs ignored without update_valid_e
        pc_e        = 32'h300;
        is_branch_e = 1'b1;
        taken_e     = 1'b1;
        target_e    = 32'h500;
        tick();
        clr_upd();
        look("no_valid", 32'h300, 1'b0, 32'h304);

        // Aliasing non-branch invalidates; not-taken miss does not allocate
        upd(32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        look("alias_inv", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
        look("nt_noalloc", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h80);
        look("realloc", 32'h100, 1'b1, 32'h80);
        upd(32'h140, 1'b1, 1'b0, 1'b1, 32'hA0);
        look("replace_new", 32'h140, 1'b1, 32'hA0);
        look("replace_old", 32'h100, 1'b0, 32'h104);
        look("other_idx", 32'h104, 1'b0, 32'h108);
        look("tag_miss", 32'h1C0, 1'b0, 32'h1C4);

        // Jump flag forces taken regardless of counter
        upd(32'h180, 1'b0, 1'b1, 1'b1, 32'hC0);
        upd(32'h180, 1'b0, 1'b1, 1'b0, 32'h0);
        upd(32'h180, 1'b0, 1'b1, 1'b0, 32'h0);
        look("jump_snt", 32'h180, 1'b1, 32'hC0);
        upd(32'h180, 1'b1, 1'b0, 1'b0, 32'h0);
        look("jump_clr", 32'h180, 1'b0, 32'h184);

        // Reset wins over a simultaneous allocating update
        upd(32'h104, 1'b1, 1'b0, 1'b1, 32'hD0);
        look("pre_rst", 32'h104, 1'b1, 32'hD0);
        set_upd(32'h240, 1'b1, 1'b0, 1'b1, 32'hE0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clr_upd();
        look("rst_upd", 32'h240, 1'b0, 32'h244);
        look("rst_clear", 32'h104, 1'b0, 32'h108);
`ifdef BP_STATS_EN
        chk("stat_br", stat_branches, 32'd0);
        chk("stat_misp", stat_mispredicts, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
